// File: rtl/fb_rd_ctr.sv
// Frame-buffer read controller: turns VGA pixel requests into BRAM port-B reads,
// rotates between NUM_BUF frame buffers at frame boundaries and tags returned pixels.
module fb_rd_ctr #(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int PIX_W   = 8,
    parameter int ADDR_W  = 20,
    parameter int RD_LAT  = 2,
    parameter int NUM_BUF = 2,
    localparam int BUF_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bram_en_i,
    input  logic              frame_start_i,
    input  logic              swap_req_i,
    output logic              enb_o,
    output logic              web_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [PIX_W-1:0]  d2memb_o,
    input  logic [PIX_W-1:0]  mem2db_i,
    output logic [PIX_W-1:0]  pixel_o,
    output logic              pixel_en_o,
    output logic              pixel_sof_o,
    output logic              pixel_eol_o,
    output logic [BUF_W-1:0]  cur_buf_o,
    output logic              swap_ack_o,
    output logic              frame_done_o,
    output logic              sync_err_o
);

    localparam int COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam int ROW_W = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAX_COL - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MAX_ROW - 1);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(MAX_ROW * MAX_COL);
    localparam logic [BUF_W-1:0]  LAST_BUF = BUF_W'(NUM_BUF - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BUF_W-1:0]    curBuf_q, curBuf_d;
    logic                swapPending_q, swapPending_d;
    logic [RD_LAT-1:0]   vldPipe_q, sofPipe_q, eolPipe_q;
    logic                swapAck_q, frameDone_q, syncErr_q;

    logic                running, active, issue, lastNow, boundary, forced, swapNow;
    logic [COL_W-1:0]    srcCol;
    logic [ROW_W-1:0]    srcRow;
    logic [ADDR_W-1:0]   srcOff;
    logic                srcLast;
    logic [ADDR_W-1:0]   addr;

    assign running  = rst_n && (state_q == RUN);
    assign active   = rst_n && ((state_q == RUN) || frame_start_i);
    assign issue    = active && bram_en_i;
    assign lastNow  = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign boundary = running && (frame_start_i || (bram_en_i && lastNow));
    // A frame start that lands on the natural last-pixel wrap is absorbed by that wrap.
    assign forced   = running && frame_start_i && !(bram_en_i && lastNow);
    assign swapNow  = boundary && (swapPending_q || swap_req_i);

    always_comb begin
        curBuf_d      = curBuf_q;
        base_d        = base_q;
        swapPending_d = swapPending_q | swap_req_i;
        if (swapNow) begin
            swapPending_d = 1'b0;
            if (curBuf_q == LAST_BUF) begin
                curBuf_d = '0;
                base_d   = '0;
            end else begin
                curBuf_d = curBuf_q + BUF_W'(1);
                base_d   = base_q + FRAME_SZ;
            end
        end

        srcCol  = forced ? '0 : col_q;
        srcRow  = forced ? '0 : row_q;
        srcOff  = forced ? '0 : offset_q;
        srcLast = (srcRow == LAST_ROW) && (srcCol == LAST_COL);

        col_d    = srcCol;
        row_d    = srcRow;
        offset_d = srcOff;
        if (issue) begin
            if (srcLast) begin
                col_d    = '0;
                row_d    = '0;
                offset_d = '0;
            end else if (srcCol == LAST_COL) begin
                col_d    = '0;
                row_d    = srcRow + ROW_W'(1);
                offset_d = srcOff + ADDR_W'(1);
            end else begin
                col_d    = srcCol + COL_W'(1);
                offset_d = srcOff + ADDR_W'(1);
            end
        end

        addr = (forced ? base_d : base_q) + srcOff;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            offset_q      <= '0;
            base_q        <= '0;
            curBuf_q      <= '0;
            swapPending_q <= 1'b0;
            vldPipe_q     <= '0;
            sofPipe_q     <= '0;
            eolPipe_q     <= '0;
            swapAck_q     <= 1'b0;
            frameDone_q   <= 1'b0;
            syncErr_q     <= 1'b0;
        end else begin
            if (active) begin
                state_q <= RUN;
            end
            col_q         <= col_d;
            row_q         <= row_d;
            offset_q      <= offset_d;
            base_q        <= base_d;
            curBuf_q      <= curBuf_d;
            swapPending_q <= swapPending_d;
            vldPipe_q[0]  <= issue;
            sofPipe_q[0]  <= issue && (srcRow == '0) && (srcCol == '0);
            eolPipe_q[0]  <= issue && (srcCol == LAST_COL);
            for (int i = 1; i < RD_LAT; i++) begin
                vldPipe_q[i] <= vldPipe_q[i-1];
                sofPipe_q[i] <= sofPipe_q[i-1];
                eolPipe_q[i] <= eolPipe_q[i-1];
            end
            swapAck_q   <= swapNow;
            frameDone_q <= issue && srcLast;
            syncErr_q   <= forced && (offset_q != '0);
        end
    end

    assign enb_o        = issue;
    assign web_o        = 1'b0;
    assign d2memb_o     = '0;
    assign addrb_o      = active ? addr : '0;
    assign pixel_en_o   = rst_n && vldPipe_q[RD_LAT-1];
    assign pixel_sof_o  = pixel_en_o && sofPipe_q[RD_LAT-1];
    assign pixel_eol_o  = pixel_en_o && eolPipe_q[RD_LAT-1];
    assign pixel_o      = pixel_en_o ? mem2db_i : '0;
    assign cur_buf_o    = curBuf_q;
    assign swap_ack_o   = swapAck_q;
    assign frame_done_o = frameDone_q;
    assign sync_err_o   = syncErr_q;

endmodule

// File: doc/fb_rd_ctr.md
Name: fb_rd_ctr

Overview:
- Parametrised frame-buffer read controller between a multi-frame BRAM (port B, read-only) and the VGA pixel pipeline.
- Each VGA pixel request becomes one BRAM read. Read data is returned with a valid flag plus start-of-frame and end-of-line markers, delayed by a configurable BRAM latency.
- Supports NUM_BUF frame buffers with a swap mechanism that takes effect only at frame boundaries, and mid-frame resynchronisation.

Parameters:
- MAX_ROW, 540, rows per frame.
- MAX_COL, 540, pixels per row.
- PIX_W, 8, pixel data width.
- ADDR_W, 20, BRAM address width; must satisfy 2^ADDR_W >= NUM_BUF*MAX_ROW*MAX_COL.
- RD_LAT, 2, BRAM read latency in cycles (1..4).
- NUM_BUF, 2, number of frame buffers (1..4); BUF_W = max(1, clog2(NUM_BUF)).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- bram_en_i  in  1  pixel request from VGA timing; one read per cycle high
- frame_start_i  in  1  pulse; current cycle is pixel 0 of a new frame
- swap_req_i  in  1  pulse; advance to next buffer at next frame boundary
- enb_o  out  1  BRAM port enable
- web_o  out  1  BRAM write enable, tied 0
- addrb_o  out  ADDR_W  BRAM address
- d2memb_o  out  PIX_W  BRAM write data, tied 0
- mem2db_i  in  PIX_W  BRAM read data
- pixel_o  out  PIX_W  pixel to VGA; 0 when not valid
- pixel_en_o  out  1  pixel_o valid
- pixel_sof_o  out  1  with pixel_en_o: pixel is row 0, col 0
- pixel_eol_o  out  1  with pixel_en_o: pixel is col MAX_COL-1
- cur_buf_o  out  BUF_W  buffer currently being read
- swap_ack_o  out  1  1-cycle pulse when a swap is applied
- frame_done_o  out  1  1-cycle pulse, cycle after last pixel read issued
- sync_err_o  out  1  1-cycle pulse, frame_start_i arrived mid-frame

Behaviour:
- Reset: state IDLE; col, row, cur_buf, swap_pending = 0; latency pipeline cleared. All outputs 0.
- FSM IDLE:
  - enb_o = 0; bram_en_i is ignored.
  - frame_start_i -> RUN. If bram_en_i is also high that cycle, pixel 0 is read in that same cycle.
- FSM RUN:
  - enb_o = bram_en_i.
  - addrb_o = base + row*MAX_COL + col, combinational, where base = cur_buf*MAX_ROW*MAX_COL.
  - Implement the offset as a running pixel counter; no multiplier on the address path.
- Advance: on bram_en_i, col increments. At col = MAX_COL-1, col wraps to 0 and row increments. At the last pixel (row MAX_ROW-1, col MAX_COL-1) both wrap to 0, frame_done_o pulses next cycle, and a boundary occurs.
- Boundary: if swap_pending, or swap_req_i in the same cycle, then:
  - cur_buf <= (cur_buf+1) mod NUM_BUF;
  - swap_pending cleared;
  - swap_ack_o pulses next cycle.
  - The next read uses the new base.
- swap_req_i outside a boundary sets swap_pending. Repeated requests before the boundary collapse into one swap.
- NUM_BUF = 1: swap is acknowledged, cur_buf stays 0.
- frame_start_i in RUN:
  - Forces a boundary, including any pending swap.
  - The address for this cycle is the new base. If bram_en_i is high, pixel 0 is issued now and the counter moves to 1.
  - If the counter was not at 0, sync_err_o pulses next cycle; frame_done_o does not pulse.
- frame_start_i on the same cycle as the natural last-pixel wrap:
  - The last pixel is read at its own address.
  - frame_done_o pulses; sync_err_o does not.
  - The swap is applied once.
  - The next frame begins at base+0. frame_start_i is not an extra pixel 0 here, because bram_en_i was consumed by the last pixel.
- Latency pipeline:
  - The shift register of {valid, sof, eol} is RD_LAT stages, captured at issue time.
  - pixel_en_o, pixel_sof_o and pixel_eol_o appear exactly RD_LAT cycles after the enb_o cycle that issued the read.
  - pixel_o = pixel_en_o ? mem2db_i : 0.
- Gaps: bram_en_i low holds the counters and inserts bubbles; no pixel is lost or duplicated.
- web_o = 0 and d2memb_o = 0 at all times.
- Reset mid-frame: the next cycle is fully IDLE, in-flight pipeline entries are discarded, and no valid pixel is output until after a new frame_start_i.

Test Plan:
- Reset, then frame_start_i+bram_en_i held high for 540*540 cycles -> addrb_o sequences 0..291599. pixel_en_o rises at cycle RD_LAT=2. pixel_sof_o only on the first pixel; pixel_eol_o every 540th pixel. frame_done_o pulses once, then the address restarts at 0.
- swap_req_i mid-frame 0 -> no change until the wrap. Then cur_buf_o=1, swap_ack_o for 1 cycle, next addrb_o=291600. After a second swap at the next boundary, cur_buf_o=0 and base=0.
- frame_start_i at pixel 1000 with bram_en_i high -> addrb_o = base that cycle. sync_err_o for 1 cycle, no frame_done_o, following addrb_o = base+1.
- bram_en_i toggling 1,0,0,1 with mem2db_i = address LSBs -> the pixel_en_o pattern equals the bram_en_i pattern shifted by RD_LAT. pixel_o = 0 in bubbles. Addresses contiguous.
- bram_en_i high before any frame_start_i -> enb_o=0, pixel_en_o=0. Mid-frame rst_n low for 1 cycle -> all outputs 0 and no pixel_en_o until a new frame_start_i.
- RD_LAT=4, NUM_BUF=3: three swaps -> cur_buf_o 1,2,0; bases 291600, 583200, 0. pixel_en_o lags enb_o by 4 cycles.
